// File: rtl/rq_arbiter.sv
// Purpose : shares the RQ formatter request channel between NUM_REQ DMA requesters,
//           grants whole packets, allocates PCIe read tags and routes completions back.
// Latency : req_valid+req_sop at cycle N -> req_grant/rq_valid at N+1; one idle cycle between packets.
// Backpressure: rq_ready is passed to the granted requester only; others see ready low and hold.
//
// Ports:
//   user_clk, user_reset_n            clock, asynchronous active-low reset
//   req_* (per requester, flattened)  valid/ready beat handshake + packet fields
//   req_grant, req_tag                one-hot current owner, tag of current packet
//   rq_*                              muxed request bus towards the formatter
//   rc_valid/rc_request_completed/rc_tag  completion info; rc_dest one-hot owner (comb.)
//   tags_free, err_tag_release        free tag count, sticky bad-release flag
//
// Build option: define RQ_ARB_STRICT_PRIO_EN for fixed priority (lowest index wins);
// otherwise round robin.
module rq_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 256,
  parameter int NUM_TAGS   = 32
) (
  input  logic                          user_clk,
  input  logic                          user_reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [4*NUM_REQ-1:0]          req_type,
  input  logic [NUM_REQ-1:0]            req_sop,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [64*NUM_REQ-1:0]         req_addr,
  input  logic [11*NUM_REQ-1:0]         req_dw_count,
  input  logic [3*NUM_REQ-1:0]          req_tc,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_payload,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [7:0]                    req_tag,
  output logic                          rq_valid,
  output logic [3:0]                    rq_type,
  output logic                          rq_payload_sop,
  output logic                          rq_payload_last,
  output logic [63:0]                   rq_addr,
  output logic [10:0]                   rq_payload_dw_count,
  output logic [7:0]                    rq_tag,
  output logic [2:0]                    rq_tc,
  output logic [DATA_WIDTH-1:0]         rq_payload,
  input  logic                          rq_ready,
  input  logic                          rc_valid,
  input  logic                          rc_request_completed,
  input  logic [7:0]                    rc_tag,
  output logic [NUM_REQ-1:0]            rc_dest,
  output logic [8:0]                    tags_free,
  output logic                          err_tag_release
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TAG_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam logic [3:0] TYPE_MEM_RD = 4'b0000;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0]    gnt_idx;
  logic [7:0]          cur_tag;
  logic [NUM_TAGS-1:0] tag_busy;
  logic [IDX_W-1:0]    tag_owner [NUM_TAGS];

  logic [NUM_REQ-1:0]  eligible;
  logic                win_vld;
  logic [IDX_W-1:0]    win_idx;
  logic                win_is_rd;
  logic [TAG_W-1:0]    free_idx;
  logic                grant_en;
  logic                alloc;
  logic                pkt_done;

  logic                rc_in_range;
  logic [TAG_W-1:0]    rc_idx;
  logic                rc_cmpl;
  logic                rc_hit;
  logic                rel;
  logic                bad_rel;

  // A read is only eligible while a tag is available; a tag-starved read is
  // skipped so other requesters keep flowing.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] & req_sop[i] &
                    ((req_type[4*i +: 4] != TYPE_MEM_RD) | (tags_free != 9'd0));
    end
  end

`ifdef RQ_ARB_STRICT_PRIO_EN
  // Fixed priority: descending scan so the lowest eligible index is written last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;

  // Round robin: scan from rr_ptr+1 with wrap. Descending k means the candidate
  // closest after the pointer is written last and therefore wins.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (eligible[idx]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (grant_en) begin
      rr_ptr <= win_idx;
    end
  end
`endif

  assign win_is_rd = (req_type[4*int'(win_idx) +: 4] == TYPE_MEM_RD);

  // Lowest-numbered free tag; allocation reads the registered busy vector, so a
  // tag released this cycle only becomes allocatable next cycle.
  always_comb begin
    free_idx = '0;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (!tag_busy[t]) free_idx = TAG_W'(t);
    end
  end

  // FSM
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          grant_en  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (pkt_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign alloc    = grant_en & win_is_rd;
  assign pkt_done = rq_valid & rq_ready & rq_payload_last;

  // Request bus mux from the granted requester
  assign rq_valid            = (state == BUSY) & req_valid[gnt_idx];
  assign rq_type             = req_type[4*int'(gnt_idx) +: 4];
  assign rq_payload_sop      = req_sop[gnt_idx];
  assign rq_payload_last     = req_last[gnt_idx];
  assign rq_addr             = req_addr[64*int'(gnt_idx) +: 64];
  assign rq_payload_dw_count = req_dw_count[11*int'(gnt_idx) +: 11];
  assign rq_tc               = req_tc[3*int'(gnt_idx) +: 3];
  assign rq_payload          = req_payload[DATA_WIDTH*int'(gnt_idx) +: DATA_WIDTH];
  assign rq_tag              = cur_tag;
  assign req_tag             = cur_tag;

  always_comb begin
    req_ready = '0;
    if (state == BUSY) req_ready[gnt_idx] = rq_ready;
  end

  // Completion handling; out-of-range tags are dropped without flagging.
  assign rc_in_range = (int'(rc_tag) < NUM_TAGS);
  assign rc_idx      = rc_tag[TAG_W-1:0];
  assign rc_cmpl     = rc_valid & rc_request_completed;
  assign rc_hit      = rc_in_range & tag_busy[rc_idx];
  assign rel         = rc_cmpl & rc_hit;
  assign bad_rel     = rc_cmpl & rc_in_range & ~tag_busy[rc_idx];

  always_comb begin
    rc_dest = '0;
    if (rc_hit) rc_dest = NUM_REQ'(1) << tag_owner[rc_idx];
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      gnt_idx         <= '0;
      req_grant       <= '0;
      cur_tag         <= '0;
      tag_busy        <= '0;
      tags_free       <= 9'(NUM_TAGS);
      err_tag_release <= 1'b0;
      for (int t = 0; t < NUM_TAGS; t++) tag_owner[t] <= '0;
    end else begin
      if (grant_en) begin
        gnt_idx   <= win_idx;
        req_grant <= NUM_REQ'(1) << win_idx;
        cur_tag   <= win_is_rd ? 8'(free_idx) : 8'd0;
      end else if (pkt_done) begin
        req_grant <= '0;
      end
      // alloc targets a free tag and rel a busy one, so they never collide
      if (alloc) begin
        tag_busy[free_idx]  <= 1'b1;
        tag_owner[free_idx] <= win_idx;
      end
      if (rel) tag_busy[rc_idx] <= 1'b0;
      tags_free <= tags_free - {8'd0, alloc} + {8'd0, rel};
      if (bad_rel) err_tag_release <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rq_arbiter.sv
`timescale 1ns/1ps
module tb_rq_arbiter;
  localparam int NR = 2;
  localparam int DW = 256;
  localparam int NT = 32;
  localparam logic [3:0] RD = 4'b0000;
  localparam logic [3:0] WR = 4'b0001;

  logic              user_clk = 1'b0;
  logic              user_reset_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [4*NR-1:0]   req_type = '0;
  logic [NR-1:0]     req_sop = '0;
  logic [NR-1:0]     req_last = '0;
  logic [64*NR-1:0]  req_addr = '0;
  logic [11*NR-1:0]  req_dw_count = '0;
  logic [3*NR-1:0]   req_tc = '0;
  logic [DW*NR-1:0]  req_payload = '0;
  logic [NR-1:0]     req_grant;
  logic [7:0]        req_tag;
  logic              rq_valid;
  logic [3:0]        rq_type;
  logic              rq_payload_sop;
  logic              rq_payload_last;
  logic [63:0]       rq_addr;
  logic [10:0]       rq_payload_dw_count;
  logic [7:0]        rq_tag;
  logic [2:0]        rq_tc;
  logic [DW-1:0]     rq_payload;
  logic              rq_ready = 1'b1;
  logic              rc_valid = 1'b0;
  logic              rc_request_completed = 1'b0;
  logic [7:0]        rc_tag = '0;
  logic [NR-1:0]     rc_dest;
  logic [8:0]        tags_free;
  logic              err_tag_release;

  rq_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_TAGS(NT)) dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_sop(req_sop), .req_last(req_last), .req_addr(req_addr),
    .req_dw_count(req_dw_count), .req_tc(req_tc), .req_payload(req_payload),
    .req_grant(req_grant), .req_tag(req_tag),
    .rq_valid(rq_valid), .rq_type(rq_type), .rq_payload_sop(rq_payload_sop),
    .rq_payload_last(rq_payload_last), .rq_addr(rq_addr),
    .rq_payload_dw_count(rq_payload_dw_count), .rq_tag(rq_tag), .rq_tc(rq_tc),
    .rq_payload(rq_payload), .rq_ready(rq_ready),
    .rc_valid(rc_valid), .rc_request_completed(rc_request_completed), .rc_tag(rc_tag),
    .rc_dest(rc_dest), .tags_free(tags_free), .err_tag_release(err_tag_release)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [3:0]  typ;
    logic        sop;
    logic        last;
    logic [63:0] addr;
    logic [10:0] dw;
    logic [2:0]  tc;
    logic [DW-1:0] pl;
  } beat_t;

  typedef struct {
    beat_t       b;
    logic [NR-1:0] grant;
    logic [7:0]  tag;
  } exp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  beat_t q0[$];
  beat_t q1[$];
  exp_t  exp_q[$];
  int    sop_cyc[$];
  logic [NR-1:0] fire = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic beat_t mk_beat(input logic [3:0] typ, input int n, input int id, input int k);
    beat_t b;
    logic [31:0] w;
    w      = {id[23:0], k[7:0]};
    b.typ  = typ;
    b.sop  = (k == 0);
    b.last = (k == n - 1);
    b.addr = {32'h0, w};
    b.dw   = 11'(n * 8);
    b.tc   = id[2:0];
    b.pl   = {8{w}};
    return b;
  endfunction

  task automatic push_pkt(input int r, input logic [3:0] typ, input int n, input int id,
                          input logic [7:0] tag, input bit stim, input bit expect_it);
    beat_t b;
    exp_t  e;
    for (int k = 0; k < n; k++) begin
      b = mk_beat(typ, n, id, k);
      if (stim) begin
        if (r == 0) q0.push_back(b);
        else        q1.push_back(b);
      end
      if (expect_it) begin
        e.b = b;
        e.grant = NR'(1) << r;
        e.tag = tag;
        exp_q.push_back(e);
      end
    end
  endtask

  // Requester models: a beat is retired at the edge after the handshake seen at negedge.
  task automatic put(input int r, input beat_t b);
    req_type[4*r +: 4]       = b.typ;
    req_sop[r]               = b.sop;
    req_last[r]              = b.last;
    req_addr[64*r +: 64]     = b.addr;
    req_dw_count[11*r +: 11] = b.dw;
    req_tc[3*r +: 3]         = b.tc;
    req_payload[DW*r +: DW]  = b.pl;
  endtask

  always @(negedge user_clk) fire = req_valid & req_ready;

  always @(posedge user_clk) begin
    cyc++;
    #1;
    if (fire[0] && q0.size() > 0) void'(q0.pop_front());
    if (fire[1] && q1.size() > 0) void'(q1.pop_front());
    req_valid[0] = (q0.size() > 0);
    if (q0.size() > 0) put(0, q0[0]);
    req_valid[1] = (q1.size() > 0);
    if (q1.size() > 0) put(1, q1[0]);
  end

  // Scoreboard: every accepted rq beat is compared against the expected queue.
  always @(negedge user_clk) begin
    exp_t e;
    if (user_reset_n && rq_valid && rq_ready) begin
      if (rq_payload_sop) sop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 256'(rq_valid), 256'(0));
      end else begin
        e = exp_q.pop_front();
        chk("beat_grant", 256'(req_grant), 256'(e.grant));
        chk("beat_tag", 256'(rq_tag), 256'(e.tag));
        chk("beat_ctl", 256'({rq_payload_sop, rq_payload_last, rq_type}),
            256'({e.b.sop, e.b.last, e.b.typ}));
        chk("beat_addr", 256'(rq_addr), 256'(e.b.addr));
        chk("beat_dw_tc", 256'({rq_payload_dw_count, rq_tc}), 256'({e.b.dw, e.b.tc}));
        chk("beat_payload", 256'(rq_payload), 256'(e.b.pl));
      end
    end
  end

  task automatic wait_drain(input int max, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge user_clk);
      n++;
    end
    chk(tag, 256'(exp_q.size()), 256'(0));
    @(posedge user_clk);
    #1;
  endtask

  task automatic wait_sop(input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge user_clk);
      ok = rq_valid && rq_payload_sop;
    end
    chk(tag, 256'(ok), 256'(1));
  endtask

  task automatic rc_pulse(input logic [7:0] t, input logic [NR-1:0] exp_dest, input string tag);
    @(posedge user_clk);
    #1;
    rc_valid = 1'b1;
    rc_request_completed = 1'b1;
    rc_tag = t;
    @(negedge user_clk);
    chk(tag, 256'(rc_dest), 256'(exp_dest));
    @(posedge user_clk);
    #1;
    rc_valid = 1'b0;
    rc_request_completed = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b2;

    // Reset values
    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    chk("rst_rq_valid", 256'(rq_valid), 256'(0));
    chk("rst_req_ready", 256'(req_ready), 256'(0));
    chk("rst_req_grant", 256'(req_grant), 256'(0));
    chk("rst_req_tag", 256'(req_tag), 256'(0));
    chk("rst_tags_free", 256'(tags_free), 256'(NT));
    chk("rst_err", 256'(err_tag_release), 256'(0));
    chk("rst_rc_dest", 256'(rc_dest), 256'(0));
    @(posedge user_clk);
    #1;
    user_reset_n = 1'b1;

    // Both requesters post back-to-back 1-beat writes
    sop_cyc.delete();
`ifdef RQ_ARB_STRICT_PRIO_EN
    for (int k = 0; k < 4; k++) push_pkt(0, WR, 1, 'h100 + k, 8'd0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) push_pkt(1, WR, 1, 'h200 + k, 8'd0, 1'b1, 1'b1);
`else
    for (int k = 0; k < 4; k++) begin
      push_pkt(0, WR, 1, 'h100 + k, 8'd0, 1'b1, 1'b1);
      push_pkt(1, WR, 1, 'h200 + k, 8'd0, 1'b1, 1'b1);
    end
`endif
    wait_drain(100, "a_drain");
    chk("a_pkt_count", 256'(sop_cyc.size()), 256'(8));
    for (int k = 0; k + 1 < sop_cyc.size(); k++)
      chk("a_idle_gap", 256'(sop_cyc[k+1] - sop_cyc[k]), 256'(2));

    // 3-beat write stalled on beat 2
    push_pkt(0, WR, 3, 'h300, 8'd0, 1'b1, 1'b1);
    b2 = mk_beat(WR, 3, 'h300, 1);
    wait_sop("b_sop_seen");
    @(posedge user_clk);
    #1;
    rq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge user_clk);
      chk("b_stall_valid", 256'(rq_valid), 256'(1));
      chk("b_stall_payload", 256'(rq_payload), 256'(b2.pl));
      chk("b_stall_grant", 256'(req_grant), 256'(2'b01));
      chk("b_stall_ready", 256'(req_ready), 256'(0));
    end
    @(posedge user_clk);
    #1;
    rq_ready = 1'b1;
    wait_drain(50, "b_drain");

    // Exhaust the tag pool with 32 reads
    for (int k = 0; k < NT; k++) push_pkt(0, RD, 1, 'h400 + k, 8'(k), 1'b1, 1'b1);
    wait_drain(200, "c_drain");
    @(negedge user_clk);
    chk("c_tags_free_zero", 256'(tags_free), 256'(0));
    // 33rd read must wait; a write from the other requester proceeds
    push_pkt(0, RD, 1, 'h500, 8'd5, 1'b1, 1'b0);
    push_pkt(1, WR, 1, 'h501, 8'd0, 1'b1, 1'b1);
    wait_drain(50, "c_write_passes");
    for (int i = 0; i < 3; i++) begin
      @(negedge user_clk);
      chk("c_read_waits", 256'(rq_valid), 256'(0));
    end
    rc_pulse(8'd5, 2'b01, "c_rc_dest_tag5");
    push_pkt(0, RD, 1, 'h500, 8'd5, 1'b0, 1'b1);
    wait_drain(50, "c_reuse_tag5");
    @(negedge user_clk);
    chk("c_tags_free_after", 256'(tags_free), 256'(0));

    // Tag 7 moves to requester 1, then double completion
    rc_pulse(8'd7, 2'b01, "d_rc_dest_req0");
    push_pkt(1, RD, 1, 'h600, 8'd7, 1'b1, 1'b1);
    wait_drain(50, "d_drain");
    rc_pulse(8'd7, 2'b10, "d_rc_dest_req1");
    @(negedge user_clk);
    chk("d_err_clean", 256'(err_tag_release), 256'(0));
    chk("d_tags_free_one", 256'(tags_free), 256'(1));
    rc_pulse(8'd40, 2'b00, "d_rc_dest_oor");
    @(negedge user_clk);
    chk("d_oor_silent", 256'(err_tag_release), 256'(0));
    chk("d_oor_tags_free", 256'(tags_free), 256'(1));
    rc_pulse(8'd7, 2'b00, "d_rc_dest_free");
    @(negedge user_clk);
    chk("d_err_sticky", 256'(err_tag_release), 256'(1));
    chk("d_tags_free_same", 256'(tags_free), 256'(1));

    // Reset in the middle of a packet
    push_pkt(0, WR, 3, 'h700, 8'd0, 1'b1, 1'b1);
    wait_sop("e_sop_seen");
    @(posedge user_clk);
    #2;
    user_reset_n = 1'b0;
    #1;
    chk("e_rq_valid", 256'(rq_valid), 256'(0));
    chk("e_req_grant", 256'(req_grant), 256'(0));
    chk("e_req_ready", 256'(req_ready), 256'(0));
    chk("e_tags_free", 256'(tags_free), 256'(NT));
    chk("e_err_cleared", 256'(err_tag_release), 256'(0));
    q0.delete();
    q1.delete();
    exp_q.delete();
    @(posedge user_clk);
    #1;
    user_reset_n = 1'b1;
    push_pkt(1, RD, 1, 'h800, 8'd0, 1'b1, 1'b1);
    wait_drain(50, "e_post_reset_read");
    @(negedge user_clk);
    chk("e_tags_free_after", 256'(tags_free), 256'(NT - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rq_arbiter.md
# rq_arbiter

Shares the single RQ formatter request channel between NUM_REQ DMA requesters in user logic. Grants whole packets (SOP to last beat) in round-robin order, allocates a PCIe tag to every memory-read request from a free pool, and releases tags on completion via the RC parser outputs. Sits between the DMA engines and the rq_* inputs of pcie_interface, and routes each RC completion back to the requester that owns its tag.

## Interface
- NUM_REQ, 2: number of requesters (2..8)
- DATA_WIDTH, 256: RQ payload width
- NUM_TAGS, 32: tags in pool (≤256); tags 0..NUM_TAGS-1
- user_clk  in  1  user clock, all logic on rising edge
- user_reset_n  in  1  asynchronous, active-low reset
- req_valid / req_ready  in/out  NUM_REQ  per-requester beat handshake
- req_type  in  4*NUM_REQ  4'b0000 mem read, 4'b0001 mem write
- req_sop, req_last  in  NUM_REQ  first/last beat of packet
- req_addr  in  64*NUM_REQ;  req_dw_count  in  11*NUM_REQ;  req_tc  in  3*NUM_REQ
- req_payload  in  DATA_WIDTH*NUM_REQ
- req_grant  out  NUM_REQ  one-hot current owner
- req_tag  out  8  tag assigned to current packet
- rq_valid, rq_type, rq_payload_sop, rq_payload_last, rq_addr, rq_payload_dw_count, rq_tag, rq_tc, rq_payload  out  formatter request bus (widths as formatter)
- rq_ready  in  1  formatter ready
- rc_valid, rc_request_completed  in  1;  rc_tag  in  8  completion info
- rc_dest  out  NUM_REQ  one-hot owner of rc_tag (comb.)
- tags_free  out  9  free tag count
- err_tag_release  out  1  sticky, completion for non-busy tag

## Operation
- States IDLE, BUSY. IDLE: requester i eligible when req_valid[i]&req_sop[i] and (type≠read or tags_free>0). If any eligible, pick winner, register req_grant, allocate tag, go BUSY next cycle.
- Round robin: search starts at index after last winner, wrapping; pointer resets to NUM_REQ-1 so requester 0 wins first.
- Tag allocation: lowest-numbered free tag, marked busy with owner index at grant; writes get no tag, rq_tag=0.
- BUSY: rq_* = muxed signals of granted requester, rq_tag = allocated tag; req_ready[g]=rq_ready, others 0. On rq_valid&rq_ready&rq_payload_last → IDLE.
- Release: rc_valid&rc_request_completed&rc_tag<NUM_TAGS&busy → tag freed next cycle. Tag free or out of range → ignored, err_tag_release set (out-of-range ignored silently).
- Allocate and release same cycle: tags_free unchanged net; freed tag not reusable until following cycle.
- rc_dest: owner bit of rc_tag if busy, else 0.

## Timing
- Reset: rq_valid 0, req_ready 0, req_grant 0, req_tag 0, tags_free NUM_TAGS, err_tag_release 0, all tags free, state IDLE.
- Latency: req_valid/sop at cycle N → req_grant, rq_valid at N+1. One IDLE cycle between packets.
- rq_ready low mid-packet: rq_* held, req_ready low, grant held.
- Non-granted requesters must hold valid beats; never see ready.
- Reset mid-packet: aborts packet, frees all tags.
- Read with zero free tags: requester skipped, not blocked; others proceed.

## Configuration
- RQ_ARB_STRICT_PRIO_EN defined: fixed priority, lowest index wins; pointer unused.
- Not defined: round robin as above.

## Test plan
- Both requesters post 1-beat writes continuously → grants alternate 0,1,0,1; rq_tag 0; one idle cycle between.
- Requester 0 3-beat write, rq_ready low on beat 2 for 4 cycles → beats 1-3 delivered in order, no grant change.
- 32 reads back-to-back → tags 0..31, tags_free 0; 33rd read waits; completion tag 5 → next read gets tag 5.
- Completion tag 7 owned by requester 1 → rc_dest=2'b10; repeat completion tag 7 → err_tag_release=1, rc_dest=0.
- Assert user_reset_n low mid-packet → rq_valid 0 same cycle, tags_free 32 after release.
- With RQ_ARB_STRICT_PRIO_EN, both always valid → requester 0 granted every packet.
